// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the 3-stage pipeline hazard controller.
// Holds FSM state encoding, forward-select encoding and the NOP word.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        DRAIN
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_ALU,
        FWD_LD
    } fwd_sel_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// hazard_match: flags a D/E source operand written by the M/W instruction.
// Ports: i_use, i_rs, i_rd, i_reg_wr in; o_match out (x0 never matches).
module hazard_match (
    input  logic       i_use,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd,
    input  logic       i_reg_wr,
    output logic       o_match
);

    assign o_match = i_use & i_reg_wr
                   & (i_rd == i_rs)
                   & (i_rd != 5'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, load-use stall, flush/bubble and stall count.
// In: clk, rst(async low), D/E sources, M/W dest, br_taken. Out: fwd, enables.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       de_rs1_i,
    input  logic [4:0]       de_rs2_i,
    input  logic             de_use_rs1_i,
    input  logic             de_use_rs2_i,
    input  logic [4:0]       mw_rd_i,
    input  logic             mw_reg_wr_i,
    input  logic             mw_is_load_i,
    input  logic             br_taken_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             pc_en_o,
    output logic             fd_en_o,
    output logic             fd_flush_o,
    output logic             de_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    hz_state_e        r_state;
    hz_state_e        w_nxt_state;
    logic [2:0]       r_cnt;
    logic [2:0]       w_nxt_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic     w_match_a;
    logic     w_match_b;
    logic     w_ld_use;
    fwd_sel_e w_fwd_a;
    fwd_sel_e w_fwd_b;
    logic     w_pc_en;
    logic     w_fd_en;
    logic     w_flush;
    logic     w_bubble;

    hazard_match u_match_a (
        .i_use    (de_use_rs1_i),
        .i_rs     (de_rs1_i),
        .i_rd     (mw_rd_i),
        .i_reg_wr (mw_reg_wr_i),
        .o_match  (w_match_a)
    );

    hazard_match u_match_b (
        .i_use    (de_use_rs2_i),
        .i_rs     (de_rs2_i),
        .i_rd     (mw_rd_i),
        .i_reg_wr (mw_reg_wr_i),
        .o_match  (w_match_b)
    );

    assign w_ld_use = (w_match_a | w_match_b) & mw_is_load_i;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_fwd_a     = FWD_RF;
        w_fwd_b     = FWD_RF;
        w_pc_en     = 1'b1;
        w_fd_en     = 1'b1;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_ld_use) begin
                    // Load moves on to M/W; branch operands not valid yet.
                    w_pc_en = 1'b0;
                    w_fd_en = 1'b0;
                    if (LOAD_LAT == 1) begin
                        w_nxt_state = DRAIN;
                    end else begin
                        w_nxt_state = STALL;
                        w_nxt_cnt   = 3'(LOAD_LAT - 1);
                    end
                end else begin
                    w_fwd_a = w_match_a ? FWD_ALU : FWD_RF;
                    w_fwd_b = w_match_b ? FWD_ALU : FWD_RF;
                    w_flush = br_taken_i;
                end
            end
            STALL: begin
                w_pc_en   = 1'b0;
                w_fd_en   = 1'b0;
                w_bubble  = 1'b1;
                w_nxt_cnt = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_nxt_state = DRAIN;
                end
            end
            DRAIN: begin
                w_fwd_a     = w_match_a ? FWD_LD : FWD_RF;
                w_fwd_b     = w_match_b ? FWD_LD : FWD_RF;
                w_flush     = br_taken_i;
                w_nxt_state = RUN;
            end
            default: begin
                w_nxt_state = RUN;
            end
        endcase
        // Hold outputs at their idle values while reset is low.
        if (!rst) begin
            w_fwd_a  = FWD_RF;
            w_fwd_b  = FWD_RF;
            w_pc_en  = 1'b1;
            w_fd_en  = 1'b1;
            w_flush  = 1'b0;
            w_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_cnt       <= 3'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            if (!w_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign fwd_a_o     = w_fwd_a;
    assign fwd_b_o     = w_fwd_b;
    assign pc_en_o     = w_pc_en;
    assign fd_en_o     = w_fd_en;
    assign fd_flush_o  = w_flush;
    assign de_bubble_o = w_bubble;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances in parallel.
// Directed hazard scenarios, random traffic, mid-stall reset, counter saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wr, ld, br;

    logic [1:0]  a1, b1, a3, b3;
    logic        pc1, fd1, fl1, bu1;
    logic        pc3, fd3, fl3, bu3;
    logic [15:0] sc1;
    logic [3:0]  sc3;

    int checks = 0;
    int errors = 0;

    int lat  [2] = '{1, 3};
    int cmax [2] = '{65535, 15};
    int left [2];
    int nleft[2];
    int sc   [2];
    bit drn  [2];
    bit ndrn [2];
    bit epcv [2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .de_rs1_i(rs1), .de_rs2_i(rs2),
        .de_use_rs1_i(u1), .de_use_rs2_i(u2),
        .mw_rd_i(rd), .mw_reg_wr_i(wr),
        .mw_is_load_i(ld), .br_taken_i(br),
        .fwd_a_o(a1), .fwd_b_o(b1),
        .pc_en_o(pc1), .fd_en_o(fd1),
        .fd_flush_o(fl1), .de_bubble_o(bu1),
        .stall_cnt_o(sc1)
    );

    pipe_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .de_rs1_i(rs1), .de_rs2_i(rs2),
        .de_use_rs1_i(u1), .de_use_rs2_i(u2),
        .mw_rd_i(rd), .mw_reg_wr_i(wr),
        .mw_is_load_i(ld), .br_taken_i(br),
        .fwd_a_o(a3), .fwd_b_o(b3),
        .pc_en_o(pc3), .fd_en_o(fd3),
        .fd_flush_o(fl3), .de_bubble_o(bu3),
        .stall_cnt_o(sc3)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(bit iu1, int irs1, bit iu2, int irs2,
                          bit iwr, int ird, bit ild, bit ibr);
        u1  = iu1;
        rs1 = 5'(irs1);
        u2  = iu2;
        rs2 = 5'(irs2);
        wr  = iwr;
        rd  = 5'(ird);
        ld  = ild;
        br  = ibr;
    endtask

    // Reference: a pending load leaves LOAD_LAT-1 bubble cycles, then one
    // drain cycle in which matched operands take the load data.
    task automatic check_all();
        bit         ma, mb;
        logic [1:0] ea, eb;
        bit         epc, efd, efl, ebu;
        logic [31:0] oa, ob, opc, ofd, ofl, obu, osc;
        string      p;
        ma = u1 && wr && (rd == rs1) && (rd != 0);
        mb = u2 && wr && (rd == rs2) && (rd != 0);
        for (int k = 0; k < 2; k++) begin
            ea = 0; eb = 0; epc = 1; efd = 1; efl = 0; ebu = 0;
            if (!rst) begin
                left[k] = 0; drn[k] = 0; sc[k] = 0;
                nleft[k] = 0; ndrn[k] = 0;
            end else if (left[k] > 0) begin
                epc = 0; efd = 0; ebu = 1;
                nleft[k] = left[k] - 1;
                ndrn[k]  = (left[k] == 1);
            end else if (drn[k]) begin
                ea = ma ? 2 : 0;
                eb = mb ? 2 : 0;
                efl = br;
                nleft[k] = 0;
                ndrn[k]  = 0;
            end else if ((ma || mb) && ld) begin
                epc = 0; efd = 0;
                nleft[k] = lat[k] - 1;
                ndrn[k]  = (lat[k] == 1);
            end else begin
                ea = ma ? 1 : 0;
                eb = mb ? 1 : 0;
                efl = br;
                nleft[k] = 0;
                ndrn[k]  = 0;
            end
            epcv[k] = epc;
            if (k == 0) begin
                oa = 32'(a1); ob = 32'(b1); opc = 32'(pc1);
                ofd = 32'(fd1); ofl = 32'(fl1); obu = 32'(bu1);
                osc = 32'(sc1);
            end else begin
                oa = 32'(a3); ob = 32'(b3); opc = 32'(pc3);
                ofd = 32'(fd3); ofl = 32'(fl3); obu = 32'(bu3);
                osc = 32'(sc3);
            end
            p = $sformatf("L%0d", lat[k]);
            chk({p, " fwd_a"}, oa, 32'(ea));
            chk({p, " fwd_b"}, ob, 32'(eb));
            chk({p, " pc_en"}, opc, 32'(epc));
            chk({p, " fd_en"}, ofd, 32'(efd));
            chk({p, " flush"}, ofl, 32'(efl));
            chk({p, " bubble"}, obu, 32'(ebu));
            chk({p, " stall_cnt"}, osc, 32'(sc[k]));
        end
    endtask

    task automatic commit();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                left[k] = nleft[k];
                drn[k]  = ndrn[k];
                if (!epcv[k] && sc[k] < cmax[k]) sc[k]++;
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        set_in(1, 1, 1, 1, 1, 1, 1, 1);
        for (int k = 0; k < 2; k++) begin
            left[k] = 0; drn[k] = 0; sc[k] = 0;
        end
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b1;

        // ALU forward on both operands
        set_in(1, 1, 1, 1, 1, 1, 0, 0);
        cycle();
        // Load-use with taken branch held until drain
        set_in(1, 3, 0, 0, 1, 3, 1, 1);
        for (int i = 0; i < 4; i++) cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        // Writer x0: no forward, no stall
        set_in(1, 0, 1, 0, 1, 0, 1, 0);
        cycle();
        // Taken branch in plain RUN
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        for (int i = 0; i < 300; i++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 3),
                   ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 3) == 0));
            cycle();
        end

        // Reset asserted while the LOAD_LAT=3 instance is mid-stall
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle();
        set_in(1, 2, 0, 0, 1, 2, 1, 0);
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Continuous load-use until the narrow counter saturates
        set_in(1, 4, 1, 4, 1, 4, 1, 0);
        for (int i = 0; i < 40; i++) cycle();
        chk("sat L3 stall_cnt", 32'(sc3), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
